// File: rtl/m65c02_int_ctlr.sv
// m65c02_int_ctlr: prioritized 8-source interrupt controller driving the M65C02A RQST inputs
// Bit 0 has the highest priority. Each source can be edge- or level-sensitive and has
// its own enable bit. An acknowledge moves the presented source into service.
// Build option M65C02_INTCTLR_NEST_EN: a higher-priority request may nest over
// in-service sources. Without it, any in-service source masks every request, and an
// end-of-interrupt write clears the whole in-service set.
module m65c02_int_ctlr #(
    parameter logic [7:0] pDefEdge = 8'h00
) (
    input  logic       Rst,
    input  logic       Clk,
    input  logic       Rdy,
    input  logic [7:0] Src,
    input  logic [1:0] Sel,
    input  logic       WE,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       Ack,
    output logic [7:0] RQST
);
`ifdef M65C02_INTCTLR_NEST_EN
    localparam logic NEST = 1'b1;
`else
    localparam logic NEST = 1'b0;
`endif
    logic [7:0] ier, mode, pend, isr, src_q, src_qq;
    logic [7:0] isr_top, mask, elig, clr, pend_nxt, isr_eoi, isr_nxt;
    logic       wr, eoi, ack_ok;
    // Qualify CPU strobes. Eligibility is masked by the top in-service bit, and the
    // next pending and in-service sets apply an end-of-interrupt before an acknowledge.
    always_comb begin
        wr       = Rdy & WE;
        eoi      = wr & (Sel == 2'd3);
        ack_ok   = Rdy & Ack & (|RQST);
        isr_top  = isr & (~isr + 8'd1);
        mask     = NEST ? isr_top - 8'd1 : {8{~|isr}};
        elig     = pend & ier & mask;
        clr      = ((wr & (Sel == 2'd2)) ? DI : 8'h00) | (ack_ok ? RQST : 8'h00);
        pend_nxt = (mode & ((pend & ~clr) | (src_q & ~src_qq))) | (~mode & src_q);
        isr_eoi  = eoi ? (NEST ? isr & ~isr_top : 8'h00) : isr;
        isr_nxt  = ack_ok ? (NEST ? isr_eoi | RQST : RQST) : isr_eoi;
    end
    // Sample the sources, update the register file, and register the winning request.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            src_q  <= 8'h00;
            src_qq <= 8'h00;
            pend   <= 8'h00;
            isr    <= 8'h00;
            ier    <= 8'h00;
            mode   <= pDefEdge;
            RQST   <= 8'h00;
        end else begin
            src_q  <= Src;
            src_qq <= src_q;
            pend   <= pend_nxt;
            isr    <= isr_nxt;
            RQST   <= elig & (~elig + 8'd1);
            if (wr && Sel == 2'd0) ier <= DI;
            if (wr && Sel == 2'd1) mode <= DI;
        end
    end
    // Register read-back.
    always_comb DO = (Sel == 2'd0) ? ier : (Sel == 2'd1) ? mode : (Sel == 2'd2) ? pend : isr;
endmodule

// File: tb/tb_m65c02_int_ctlr.sv
// tb_m65c02_int_ctlr: table, directed and random checks of m65c02_int_ctlr against a reference model
module tb_m65c02_int_ctlr;
`ifdef M65C02_INTCTLR_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif
    localparam logic [7:0] P_DEF = 8'hA5;

    logic       Clk = 1'b0, Rst = 1'b1, Rdy = 1'b0, WE = 1'b0, Ack = 1'b0;
    logic [7:0] Src = 8'h00, DI = 8'h00;
    logic [1:0] Sel = 2'd0;
    logic [7:0] DO, RQST;
    logic [7:0] cur_src = 8'h00;
    int n_chk = 0, n_fail = 0;

    logic [7:0] m_ier, m_mode, m_pend, m_isr, m_sq, m_sqq, m_rq;

    m65c02_int_ctlr #(.pDefEdge(P_DEF)) dut (
        .Rst(Rst), .Clk(Clk), .Rdy(Rdy), .Src(Src), .Sel(Sel), .WE(WE),
        .DI(DI), .DO(DO), .Ack(Ack), .RQST(RQST)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic       rdy;
        logic [7:0] src;
        logic [1:0] sel;
        logic       we;
        logic [7:0] di;
        logic       ack;
        logic [7:0] rq;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_do(input logic [1:0] s);
        return (s == 2'd0) ? m_ier : (s == 2'd1) ? m_mode : (s == 2'd2) ? m_pend : m_isr;
    endfunction

    task automatic model_reset;
        m_ier = 8'h00; m_mode = P_DEF; m_pend = 8'h00; m_isr = 8'h00;
        m_sq = 8'h00; m_sqq = 8'h00; m_rq = 8'h00;
    endtask

    // Advance the model one clock from the inputs currently on the pins.
    task automatic model_tick;
        int hi = 8;
        int win = 8;
        int a = 8;
        logic [7:0] nrq = 8'h00;
        logic [7:0] np = 8'h00;
        logic [7:0] ni;
        bit wr_ok, ack_ok;
        for (int i = 7; i >= 0; i--) if (m_isr[i]) hi = i;
        for (int i = 7; i >= 0; i--)
            if (m_pend[i] && m_ier[i] && (NEST ? (i < hi) : (hi == 8))) win = i;
        if (win < 8) nrq[win] = 1'b1;
        wr_ok  = Rdy && WE;
        ack_ok = Rdy && Ack && (m_rq != 8'h00);
        for (int i = 0; i < 8; i++) if (m_rq[i]) a = i;
        for (int i = 0; i < 8; i++) begin
            if (!m_mode[i]) np[i] = m_sq[i];
            else if (m_sq[i] && !m_sqq[i]) np[i] = 1'b1;
            else if ((wr_ok && Sel == 2'd2 && DI[i]) || (ack_ok && a == i)) np[i] = 1'b0;
            else np[i] = m_pend[i];
        end
        ni = m_isr;
        if (wr_ok && Sel == 2'd3 && hi < 8) begin
            if (NEST) ni[hi] = 1'b0;
            else ni = 8'h00;
        end
        if (ack_ok) begin
            if (!NEST) ni = 8'h00;
            ni[a] = 1'b1;
        end
        if (wr_ok && Sel == 2'd0) m_ier = DI;
        if (wr_ok && Sel == 2'd1) m_mode = DI;
        m_pend = np;
        m_isr  = ni;
        m_rq   = nrq;
        m_sqq  = m_sq;
        m_sq   = Src;
    endtask

    // Called at a falling edge: drive, clock once, compare at the next falling edge.
    task automatic step(input logic rdy, input logic [7:0] src, input logic [1:0] sel,
                        input logic we, input logic [7:0] di, input logic ack);
        Rdy = rdy; Src = src; Sel = sel; WE = we; DI = di; Ack = ack;
        model_tick();
        @(negedge Clk);
        chk("rqst_model", RQST, m_rq);
        chk("do_model", DO, m_do(Sel));
    endtask

    task automatic idle(input logic [1:0] sel);
        step(1'b1, cur_src, sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] di);
        step(1'b1, cur_src, sel, 1'b1, di, 1'b0);
    endtask

    task automatic ack_step;
        step(1'b1, cur_src, 2'd3, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic eoi;
        wr(2'd3, 8'h00);
    endtask

    task automatic pulse(input logic [7:0] bits);
        cur_src = bits; idle(2'd0);
        cur_src = 8'h00; idle(2'd0); idle(2'd0);
    endtask

    // Asserted mid-cycle so an immediate RQST drop proves the reset is asynchronous.
    task automatic do_reset;
        Rst = 1'b1; Src = 8'h00; cur_src = 8'h00; WE = 1'b0; Ack = 1'b0;
        #1;
        model_reset();
        chk("rst_rqst", RQST, 8'h00);
        for (int s = 0; s < 4; s++) begin
            Sel = 2'(s);
            #1;
            chk("rst_do", DO, (s == 1) ? P_DEF : 8'h00);
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h00, 2'd0, 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF};
        tbl[1] = '{1'b1, 8'h00, 2'd1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF};
        tbl[2] = '{1'b1, 8'h08, 2'd2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 8'h00, 2'd2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h08};
        tbl[4] = '{1'b1, 8'h00, 2'd2, 1'b0, 8'h00, 1'b0, 8'h08, 8'h08};
        tbl[5] = '{1'b1, 8'h00, 2'd3, 1'b0, 8'h00, 1'b1, 8'h08, 8'h08};
        tbl[6] = '{1'b1, 8'h00, 2'd2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        tbl[7] = '{1'b1, 8'h00, 2'd3, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00};

        @(negedge Clk);
        do_reset();

        for (int v = 0; v < 8; v++) begin
            step(tbl[v].rdy, tbl[v].src, tbl[v].sel, tbl[v].we, tbl[v].di, tbl[v].ack);
            chk($sformatf("tbl%0d_rqst", v), RQST, tbl[v].rq);
            chk($sformatf("tbl%0d_do", v), DO, tbl[v].dout);
        end

        pulse(8'h24);
        chk("prio_rqst", RQST, 8'h04);
        ack_step();
        chk("prio_isr", DO, 8'h04);
        idle(2'd2);
        chk("prio_pend", DO, 8'h20);
        chk("prio_masked", RQST, 8'h00);
        eoi();
        chk("prio_eoi", DO, 8'h00);
        idle(2'd0);
        chk("prio_next", RQST, 8'h20);
        ack_step(); eoi(); idle(2'd0);

        pulse(8'h10);
        chk("nest_first", RQST, 8'h10);
        ack_step();
        chk("nest_isr1", DO, 8'h10);
        idle(2'd0);
        pulse(8'h02);
        chk("nest_rqst", RQST, NEST ? 8'h02 : 8'h00);
        ack_step();
        chk("nest_isr2", DO, NEST ? 8'h12 : 8'h10);
        eoi();
        chk("nest_eoi", DO, NEST ? 8'h10 : 8'h00);
        idle(2'd0); idle(2'd0);
        chk("nest_after", RQST, NEST ? 8'h00 : 8'h02);
        ack_step(); eoi(); eoi(); idle(2'd3);
        chk("nest_clean", DO, 8'h00);

        wr(2'd1, 8'h00);
        cur_src = 8'h80;
        idle(2'd0); idle(2'd0); idle(2'd0);
        chk("lvl_rqst", RQST, 8'h80);
        ack_step();
        chk("lvl_isr", DO, 8'h80);
        idle(2'd2);
        chk("lvl_pend", DO, 8'h80);
        cur_src = 8'h00;
        idle(2'd0); idle(2'd0); idle(2'd0);
        eoi(); idle(2'd2);
        chk("lvl_rqst_off", RQST, 8'h00);
        chk("lvl_pend_off", DO, 8'h00);
        wr(2'd1, 8'hFF);

        ack_step();
        chk("ack_idle_isr", DO, 8'h00);
        cur_src = 8'h10;
        idle(2'd0);
        wr(2'd2, 8'h10);
        chk("w1c_vs_set", DO, 8'h10);
        idle(2'd0);
        ack_step(); eoi();
        cur_src = 8'h00;
        idle(2'd0); idle(2'd0);

        step(1'b0, cur_src, 2'd0, 1'b1, 8'h01, 1'b0);
        chk("rdy0_ier", DO, 8'hFF);
        cur_src = 8'h01;
        step(1'b0, cur_src, 2'd2, 1'b0, 8'h00, 1'b0);
        step(1'b0, cur_src, 2'd2, 1'b0, 8'h00, 1'b0);
        chk("rdy0_capture", DO, 8'h01);
        cur_src = 8'h00;
        idle(2'd0); ack_step(); eoi(); idle(2'd0);

        pulse(8'h04);
        chk("pre_reset_rqst", RQST, 8'h04);
        do_reset();
        wr(2'd0, 8'hFF);

        for (int n = 0; n < 3000; n++) begin
            logic rdy, ack, we;
            rdy = ($urandom_range(7) != 0);
            we  = ($urandom_range(5) == 0);
            ack = (m_rq != 8'h00) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
            cur_src = cur_src ^ 8'($urandom & $urandom & $urandom);
            step(rdy, cur_src, 2'($urandom_range(3)), we, 8'($urandom), ack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
